// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI master among N_REQ requesters.
// It runs multi-word transfers and aborts through a watchdog when the master stalls.
module spi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = 8,
    parameter int CLK_DIV = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ-1:0][1:0]         slv_i,
    input  logic [N_REQ-1:0][3:0]         len_i,
    input  logic [N_REQ-1:0][D_WIDTH-1:0] txd_i,
    output logic [N_REQ-1:0]              gnt_o,
    output logic                          tx_next_o,
    output logic                          rx_valid_o,
    output logic [D_WIDTH-1:0]            rx_word_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic                          spi_enable_o,
    output logic                          spi_cont_o,
    output logic [31:0]                   spi_addr_o,
    output logic [D_WIDTH-1:0]            spi_tx_data_o,
    output logic [31:0]                   spi_clk_div_o,
    input  logic                          spi_busy_i,
    input  logic [D_WIDTH-1:0]            spi_rx_data_i
);

    localparam int          IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] WD_LIM = 16'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, XFER, DONE} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d, idx_q, idx_d;
    logic [1:0]           slv_q, slv_d;
    logic [4:0]           bl_q, bl_d;
    logic [15:0]          wd_q, wd_d;
    logic                 busy_q;
    logic                 tx_next_q, tx_next_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [D_WIDTH-1:0]   rx_word_q, rx_word_d;
    logic                 err_q, err_d;

    logic [IW-1:0]        pick, cand;
    logic                 found;
    logic                 rise, fall, wd_hit;
    logic [4:0]           bl_dec;

    // First requesting index at or above rr_q, wrapping round.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(rr_q) + i) % N_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign rise   = spi_busy_i & ~busy_q;
    assign fall   = busy_q & ~spi_busy_i;
    assign wd_hit = (wd_q >= WD_LIM);
    assign bl_dec = bl_q - 5'd1;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        idx_d      = idx_q;
        slv_d      = slv_q;
        bl_d       = bl_q;
        tx_next_d  = 1'b0;
        rx_valid_d = 1'b0;
        rx_word_d  = rx_word_q;
        err_d      = err_q;
        // Any busy edge is proof of life from the master.
        if (rise || fall)
            wd_d = '0;
        else if (state_q == WAIT_BUSY || state_q == XFER)
            wd_d = wd_q + 16'd1;
        else
            wd_d = wd_q;

        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (found && !spi_busy_i) begin
                    state_d = LOAD;
                    idx_d   = pick;
                    slv_d   = slv_i[pick];
                    bl_d    = 5'(len_i[pick]) + 5'd1;
                    wd_d    = '0;
                end
            end
            LOAD: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (rise) begin
                    tx_next_d = (bl_q > 5'd1);
                    state_d   = XFER;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            XFER: begin
                // Only the falling edge ends a word; a continuation re-rise is ignored.
                if (fall) begin
                    rx_valid_d = 1'b1;
                    rx_word_d  = spi_rx_data_i;
                    bl_d       = bl_dec;
                    tx_next_d  = (bl_dec > 5'd1);
                    if (bl_dec == 5'd0) state_d = DONE;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                rr_d    = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            idx_q      <= '0;
            slv_q      <= '0;
            bl_q       <= '0;
            wd_q       <= '0;
            busy_q     <= 1'b0;
            tx_next_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_word_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            slv_q      <= slv_d;
            bl_q       <= bl_d;
            wd_q       <= wd_d;
            busy_q     <= spi_busy_i;
            tx_next_q  <= tx_next_d;
            rx_valid_q <= rx_valid_d;
            rx_word_q  <= rx_word_d;
            err_q      <= err_d;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_gnt
        assign gnt_o[g] = (state_q != IDLE) && (idx_q == IW'(g));
    end

    assign tx_next_o     = tx_next_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_word_o     = rx_word_q;
    assign done_o        = (state_q == DONE);
    assign err_o         = (state_q == DONE) && err_q;
    assign spi_enable_o  = (state_q == LOAD);
    assign spi_cont_o    = (state_q == LOAD || state_q == WAIT_BUSY || state_q == XFER) && (bl_q > 5'd1);
    assign spi_addr_o    = {30'd0, slv_q};
    assign spi_tx_data_o = txd_i[idx_q];
    assign spi_clk_div_o = 32'(CLK_DIV);

endmodule
